// File: rtl/ss_pkg.sv
// Shared definitions for the free-list controller: default sizes, the PRF tag
// type and the controller's recovery state encoding.
package ss_pkg;

    localparam int SS_WIDTH    = 2;
    localparam int SS_PRF_SIZE = 64;
    localparam int SS_RR_SIZE  = 32;

    localparam int PRF_TAG_W = $clog2(SS_PRF_SIZE);

    typedef logic [PRF_TAG_W-1:0] prf_tag_t;

    typedef enum logic {
        FL_IDLE    = 1'b0,
        FL_RECOVER = 1'b1
    } fl_state_t;

endpackage

// File: rtl/ss_lowest_pick.sv
// Finds the lowest set bit of a vector, reports its index and returns the
// vector with that bit cleared so stages can be chained lane after lane.
module ss_lowest_pick #(
    parameter int N  = 64,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  vec_i,
    output logic          found_o,
    output logic [IW-1:0] idx_o,
    output logic [N-1:0]  rest_o
);

    localparam logic [N-1:0] ONE_V = {{(N-1){1'b0}}, 1'b1};

    assign found_o = |vec_i;

    // Subtracting one flips the lowest set bit and the zeros below it, so the
    // AND removes exactly that bit.
    assign rest_o = vec_i & (vec_i - ONE_V);

    // Scan from the top so the last hit written is the lowest set index.
    always_comb begin
        idx_o = '0;
        for (int i = N - 1; i >= 0; i--) begin
            idx_o = vec_i[i] ? IW'(i) : idx_o;
        end
    end

endmodule

// File: rtl/ss_freelist_ctrl.sv
// Physical-register free list: hands out the lowest free PRF tags to dispatch
// lanes in order, reclaims tags released at retirement and rebuilds the free
// set from the committed map on a rollback.
module ss_freelist_ctrl
    import ss_pkg::*;
#(
    parameter int WIDTH    = SS_WIDTH,
    parameter int PRF_SIZE = SS_PRF_SIZE,
    parameter int RR_SIZE  = SS_RR_SIZE,
    localparam int TAG_W   = $clog2(PRF_SIZE),
    localparam int CNT_W   = $clog2(PRF_SIZE + 1)
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic [WIDTH-1:0]              alloc_req,
    output logic [WIDTH-1:0]              alloc_gnt,
    output logic [WIDTH-1:0][TAG_W-1:0]   alloc_tag,
    input  logic [WIDTH-1:0]              free_en,
    input  logic [WIDTH-1:0][TAG_W-1:0]   free_tag,
    input  logic                          rollback,
    input  logic [RR_SIZE-1:0][TAG_W-1:0] rrat_table,
    output logic [CNT_W-1:0]              free_count,
    output logic                          ready
);

    localparam logic [PRF_SIZE-1:0] ONE_V     = {{(PRF_SIZE-1){1'b0}}, 1'b1};
    // Architectural registers start identity-mapped onto the low tags.
    localparam logic [PRF_SIZE-1:0] RESET_VEC = {PRF_SIZE{1'b1}} << RR_SIZE;
    localparam logic [CNT_W-1:0]    RESET_CNT = CNT_W'(PRF_SIZE - RR_SIZE);

    function automatic logic [CNT_W-1:0] popcount(input logic [PRF_SIZE-1:0] v);
        logic [CNT_W-1:0] c;
        c = '0;
        for (int i = 0; i < PRF_SIZE; i++) begin
            c = c + {{(CNT_W-1){1'b0}}, v[i]};
        end
        return c;
    endfunction

    logic [PRF_SIZE-1:0]             free_vec_q;
    logic [PRF_SIZE-1:0]             free_vec_d;
    logic [CNT_W-1:0]                free_count_q;
    fl_state_t                       state_q;

    logic [WIDTH:0][PRF_SIZE-1:0]    chain_s;
    logic [WIDTH-1:0]                found_s;
    logic [WIDTH-1:0][TAG_W-1:0]     pick_tag_s;
    logic [WIDTH-1:0]                gnt_s;
    logic                            prefix_s;
    logic                            ready_s;
    logic [PRF_SIZE-1:0]             after_alloc_s;
    logic [PRF_SIZE-1:0]             rel_mask_s;
    logic [PRF_SIZE-1:0]             in_use_s;

    // Lane g picks from whatever the lower lanes left behind.
    assign chain_s[0] = free_vec_q;

    genvar g;
    generate
        for (g = 0; g < WIDTH; g++) begin : g_pick
            ss_lowest_pick #(
                .N  (PRF_SIZE),
                .IW (TAG_W)
            ) u_pick (
                .vec_i   (chain_s[g]),
                .found_o (found_s[g]),
                .idx_o   (pick_tag_s[g]),
                .rest_o  (chain_s[g+1])
            );
        end
    endgenerate

    // Allocation is blocked in a flush cycle as well as while recovering.
    assign ready_s = (state_q == FL_IDLE) && !rollback;

    // A lane is granted only while every lower lane is requesting and granted,
    // and its own pick stage still found a tag.
    always_comb begin
        gnt_s    = '0;
        prefix_s = ready_s;
        for (int h = 0; h < WIDTH; h++) begin
            prefix_s = prefix_s & alloc_req[h] & found_s[h];
            gnt_s[h] = prefix_s;
        end
    end

    // Grants form a prefix, so the vector left after allocation is simply the
    // chain stage just past the last granted lane.
    always_comb begin
        after_alloc_s = chain_s[0];
        for (int h = 0; h < WIDTH; h++) begin
            after_alloc_s = gnt_s[h] ? chain_s[h+1] : after_alloc_s;
        end
    end

    // Tags returned by retirement this cycle; duplicates simply OR together.
    always_comb begin
        rel_mask_s = '0;
        for (int h = 0; h < WIDTH; h++) begin
            rel_mask_s = rel_mask_s | (free_en[h] ? (ONE_V << free_tag[h]) : '0);
        end
    end

    // Every tag named by the committed map is in use after a flush.
    always_comb begin
        in_use_s = '0;
        for (int r = 0; r < RR_SIZE; r++) begin
            in_use_s = in_use_s | (ONE_V << rrat_table[r]);
        end
    end

    // Frees are applied after grants so a redundant free can never drop a bit;
    // a flush discards both and rebuilds from the committed map.
    always_comb begin
        if (rollback) begin
            free_vec_d = ~in_use_s;
        end else begin
            free_vec_d = after_alloc_s | rel_mask_s;
        end
    end

    // Free vector and its population count advance together.
    always_ff @(posedge clock) begin
        if (reset) begin
            free_vec_q   <= RESET_VEC;
            free_count_q <= RESET_CNT;
        end else begin
            free_vec_q   <= free_vec_d;
            free_count_q <= popcount(free_vec_d);
        end
    end

    // Recovery FSM: a flush always lands in RECOVER, which lasts one cycle.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= FL_IDLE;
        end else if (rollback) begin
            state_q <= FL_RECOVER;
        end else begin
            case (state_q)
                FL_IDLE:    state_q <= FL_IDLE;
                FL_RECOVER: state_q <= FL_IDLE;
                default:    state_q <= FL_IDLE;
            endcase
        end
    end

    assign alloc_gnt  = gnt_s;
    assign alloc_tag  = pick_tag_s;
    assign free_count = free_count_q;
    assign ready      = ready_s;

endmodule

// File: tb/tb_ss_freelist_ctrl.sv
// Bench for the free-list controller: a set-of-free-tags model predicts every
// cycle's grants, tags, readiness and count; directed scenarios pin the model
// with literal expectations, then random traffic runs against it.
module tb_ss_freelist_ctrl;

    localparam int W  = 2;
    localparam int P  = 64;
    localparam int R  = 32;
    localparam int TW = 6;
    localparam int CW = 7;

    logic                  clock = 1'b0;
    logic                  reset;
    logic [W-1:0]          alloc_req;
    logic [W-1:0]          alloc_gnt;
    logic [W-1:0][TW-1:0]  alloc_tag;
    logic [W-1:0]          free_en;
    logic [W-1:0][TW-1:0]  free_tag;
    logic                  rollback;
    logic [R-1:0][TW-1:0]  rrat_table;
    logic [CW-1:0]         free_count;
    logic                  ready;

    ss_freelist_ctrl #(.WIDTH(W), .PRF_SIZE(P), .RR_SIZE(R)) dut (
        .clock      (clock),
        .reset      (reset),
        .alloc_req  (alloc_req),
        .alloc_gnt  (alloc_gnt),
        .alloc_tag  (alloc_tag),
        .free_en    (free_en),
        .free_tag   (free_tag),
        .rollback   (rollback),
        .rrat_table (rrat_table),
        .free_count (free_count),
        .ready      (ready)
    );

    always #5 clock = ~clock;

    int    n_cmp = 0;
    int    n_bad = 0;
    bit    fm[P];          // model: fm[p] = tag p is free
    bit    rec_m;          // model: in the recovery cycle
    bit    model_ok = 1'b0;
    int    pool[$];        // tags handed out and legal to free later
    logic [W-1:0] g_gnt;
    int    g_tag[W];
    int    g_cnt;
    logic  g_rdy;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic pool_remove(input int t);
        for (int i = 0; i < pool.size(); i++) begin
            if (pool[i] == t) begin
                pool.delete(i);
                break;
            end
        end
    endtask

    // One clock cycle: drive, compare against the model, advance the model.
    task automatic cyc(input logic [1:0] req, input logic [1:0] fen,
                       input int t0, input int t1, input logic rb, input logic rst);
        int fl[$];
        logic [W-1:0] eg;
        logic pref;
        alloc_req   = req;
        free_en     = fen;
        free_tag[0] = t0[TW-1:0];
        free_tag[1] = t1[TW-1:0];
        rollback    = rb;
        reset       = rst;
        @(negedge clock);
        g_gnt    = alloc_gnt;
        g_tag[0] = int'(alloc_tag[0]);
        g_tag[1] = int'(alloc_tag[1]);
        g_cnt    = int'(free_count);
        g_rdy    = ready;
        for (int p = 0; p < P; p++) if (fm[p]) fl.push_back(p);
        eg   = '0;
        pref = !rec_m && !rb;
        for (int h = 0; h < W; h++) begin
            pref  = pref && req[h] && (fl.size() > h);
            eg[h] = pref;
        end
        if (model_ok) begin
            chk("free_count", 32'(free_count), fl.size());
            if (!rst) begin
                chk("ready", 32'(ready), 32'(!rec_m && !rb));
                chk("alloc_gnt", 32'(alloc_gnt), 32'(eg));
                for (int h = 0; h < W; h++)
                    if (eg[h]) chk("alloc_tag", 32'(alloc_tag[h]), fl[h]);
            end
            if (!rst && !rb) begin
                for (int h = 0; h < W; h++)
                    if (fen[h]) assert (!fm[h == 0 ? t0 : t1])
                        else $error("illegal free of an already free tag");
                if (fen == 2'b11) assert (t0 != t1)
                    else $error("duplicate free_tag across lanes");
            end
        end
        if (rst) begin
            for (int p = 0; p < P; p++) fm[p] = (p >= R);
            rec_m    = 1'b0;
            model_ok = 1'b1;
            pool.delete();
        end else if (rb) begin
            for (int p = 0; p < P; p++) fm[p] = 1'b1;
            for (int r = 0; r < R; r++) fm[int'(rrat_table[r])] = 1'b0;
            rec_m = 1'b1;
            pool.delete();
        end else begin
            for (int h = 0; h < W; h++) begin
                if (eg[h]) begin
                    fm[fl[h]] = 1'b0;
                    pool.push_back(fl[h]);
                end
            end
            if (fen[0]) fm[t0] = 1'b1;
            if (fen[1]) fm[t1] = 1'b1;
            rec_m = 1'b0;
        end
        @(posedge clock);
        #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int a, b, seen45, idx, t0, t1;
        int perm[P];
        logic [1:0] fen;
        logic rb, rst;

        alloc_req = '0; free_en = '0; free_tag = '0; rollback = 1'b0; reset = 1'b1;
        for (int r = 0; r < R; r++) rrat_table[r] = TW'(r);
        @(posedge clock); #1;
        cyc(2'b00, 2'b00, 0, 0, 1'b0, 1'b1);
        cyc(2'b00, 2'b00, 0, 0, 1'b0, 1'b1);

        // First grants after reset.
        cyc(2'b11, 2'b00, 0, 0, 1'b0, 1'b0);
        chk("rst_count", g_cnt, 32);
        chk("rst_ready", g_rdy, 1);
        chk("first_gnt", g_gnt, 2'b11);
        chk("first_tag0", g_tag[0], 32);
        chk("first_tag1", g_tag[1], 33);
        cyc(2'b11, 2'b00, 0, 0, 1'b0, 1'b0);
        chk("second_count", g_cnt, 30);
        chk("second_tag0", g_tag[0], 34);
        chk("second_tag1", g_tag[1], 35);

        // Drain until only tag 63 is left.
        repeat (13) cyc(2'b11, 2'b00, 0, 0, 1'b0, 1'b0);
        cyc(2'b01, 2'b00, 0, 0, 1'b0, 1'b0);
        cyc(2'b11, 2'b00, 0, 0, 1'b0, 1'b0);
        chk("last_count", g_cnt, 1);
        chk("last_gnt", g_gnt, 2'b01);
        chk("last_tag", g_tag[0], 63);
        cyc(2'b11, 2'b00, 0, 0, 1'b0, 1'b0);
        chk("empty_gnt", g_gnt, 2'b00);
        chk("empty_count", g_cnt, 0);

        // A freed tag is not visible in its own cycle.
        pool_remove(40);
        cyc(2'b01, 2'b01, 40, 0, 1'b0, 1'b0);
        chk("same_cycle_free_gnt", g_gnt, 2'b00);
        cyc(2'b01, 2'b00, 0, 0, 1'b0, 1'b0);
        chk("refree_gnt", g_gnt, 2'b01);
        chk("refree_tag", g_tag[0], 40);

        // Return ten tags, then a request with a hole at lane 0.
        repeat (5) begin
            a = pool.pop_front();
            b = pool.pop_front();
            cyc(2'b00, 2'b11, a, b, 1'b0, 1'b0);
        end
        cyc(2'b10, 2'b00, 0, 0, 1'b0, 1'b0);
        chk("hole_count", g_cnt, 10);
        chk("hole_gnt", g_gnt, 2'b00);

        // Rollback to identity map except arch 5 -> P45.
        for (int r = 0; r < R; r++) rrat_table[r] = TW'(r);
        rrat_table[5] = 6'd45;
        cyc(2'b11, 2'b11, pool[0], pool[1], 1'b1, 1'b0);
        chk("rb_ready_T", g_rdy, 0);
        chk("rb_gnt_T", g_gnt, 2'b00);
        cyc(2'b11, 2'b00, 0, 0, 1'b0, 1'b0);
        chk("rb_ready_T1", g_rdy, 0);
        chk("rb_gnt_T1", g_gnt, 2'b00);
        cyc(2'b11, 2'b00, 0, 0, 1'b0, 1'b0);
        chk("rb_count_T2", g_cnt, 32);
        chk("rb_gnt_T2", g_gnt, 2'b11);
        chk("rb_tag0_T2", g_tag[0], 5);
        chk("rb_tag1_T2", g_tag[1], 32);
        seen45 = 0;
        repeat (20) begin
            cyc(2'b11, 2'b00, 0, 0, 1'b0, 1'b0);
            for (int h = 0; h < W; h++) if (g_gnt[h] && g_tag[h] == 45) seen45++;
        end
        chk("tag45_never_granted", seen45, 0);

        // Reset together with rollback in the middle of a drain.
        cyc(2'b00, 2'b00, 0, 0, 1'b0, 1'b1);
        repeat (12) cyc(2'b11, 2'b00, 0, 0, 1'b0, 1'b0);
        cyc(2'b01, 2'b00, 0, 0, 1'b0, 1'b0);
        cyc(2'b11, 2'b00, 0, 0, 1'b1, 1'b1);
        chk("mid_drain_count", g_cnt, 7);
        cyc(2'b11, 2'b00, 0, 0, 1'b0, 1'b0);
        chk("post_rst_count", g_cnt, 32);
        chk("post_rst_ready", g_rdy, 1);
        chk("post_rst_gnt", g_gnt, 2'b11);
        chk("post_rst_tag0", g_tag[0], 32);
        chk("post_rst_tag1", g_tag[1], 33);

        // Random traffic against the model.
        repeat (700) begin
            rb  = ($urandom_range(39, 0) == 0);
            rst = ($urandom_range(199, 0) == 0);
            if (rb) begin
                for (int i = 0; i < P; i++) perm[i] = i;
                for (int i = P - 1; i > 0; i--) begin
                    idx = $urandom_range(i, 0);
                    a = perm[i]; perm[i] = perm[idx]; perm[idx] = a;
                end
                for (int r = 0; r < R; r++) rrat_table[r] = perm[r][TW-1:0];
            end
            fen = 2'b00; t0 = 0; t1 = 0;
            if (!rb && !rst) begin
                if (pool.size() > 0 && $urandom_range(1, 0) == 1) begin
                    idx = $urandom_range(pool.size() - 1, 0);
                    t0 = pool[idx]; pool.delete(idx); fen[0] = 1'b1;
                end
                if (pool.size() > 0 && $urandom_range(1, 0) == 1) begin
                    idx = $urandom_range(pool.size() - 1, 0);
                    t1 = pool[idx]; pool.delete(idx); fen[1] = 1'b1;
                end
            end
            cyc(2'($urandom_range(3, 0)), fen, t0, t1, rb, rst);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/ss_freelist_ctrl.md
Name: ss_freelist_ctrl

Overview:
- Physical-register free-list controller; owns allocation of PRF tags to the dispatch stage.
- Tracks free tags as a registered bit-vector.
- Grants up to WIDTH in-order allocations per cycle and reclaims tags released by retirement.
- On rollback, rebuilds the free set from the retirement RAT's committed table, then holds allocation off for one recovery cycle.

Parameters:
- WIDTH, 2, superscalar lanes; tracks `WIDTH.
- PRF_SIZE, 64, physical registers; tracks `PRF_SIZE.
- RR_SIZE, 32, architectural registers; tracks `RR_SIZE.

Ports:
- clock  in  1  system clock.
- reset  in  1  synchronous, active-high reset, sampled on posedge clock.
- alloc_req  in  WIDTH  dispatch lane h wants a new tag.
- alloc_gnt  out  WIDTH  lane h granted this cycle.
- alloc_tag  out  WIDTH x $clog2(PRF_SIZE)  tag for lane h; valid only when alloc_gnt[h] is high.
- free_en  in  WIDTH  retire lane h releases a tag.
- free_tag  in  WIDTH x $clog2(PRF_SIZE)  released tag (the retiring instruction's old mapping).
- rollback  in  1  flush; rebuild the free set from rrat_table.
- rrat_table  in  RR_SIZE x $clog2(PRF_SIZE)  committed map, already including this cycle's retirements.
- free_count  out  $clog2(PRF_SIZE+1)  number of set bits in free_vec (registered state).
- ready  out  1  high in IDLE; low during rollback and RECOVER.

Behaviour:
- State: free_vec[PRF_SIZE] and a 2-state FSM {IDLE, RECOVER}.
- Reset:
  - free_vec[i] = 1 for i >= RR_SIZE, 0 otherwise (matches the identity RRAT reset).
  - FSM = IDLE; free_count = PRF_SIZE-RR_SIZE; alloc_gnt = 0.
- Allocation is combinational from registered free_vec, zero latency. Tags are removed from free_vec at the next posedge.
- Lane h is granted only if all of the following hold:
  - ready = 1;
  - alloc_req[0..h] are all 1 (requests are a prefix; any hole blocks itself and all higher lanes);
  - at least h+1 tags are free.
- Tag selection: lane 0 gets the lowest-indexed free tag, lane 1 the next-lowest, and so on. No tag is granted twice in a cycle.
- Free: for each free_en[h], set free_vec[free_tag[h]] at the posedge.
  - A freed tag is not allocatable in the same cycle; it first becomes visible the next cycle.
- Illegal inputs: freeing a tag that is already free, or duplicate free_tag across lanes in one cycle.
  - Result is bit stays 1, free_count is correct from the vector, and no corruption occurs.
  - The bench flags these with assertions.
- Rollback, cycle T (rollback = 1):
  - alloc_gnt = 0 and ready = 0 regardless of state.
  - free_en is ignored.
  - At the posedge, free_vec <= ~in_use, where in_use[p] = 1 iff any rrat_table entry equals p.
  - FSM -> RECOVER.
- RECOVER (cycle T+1): ready = 0, gnt = 0, free_en honoured, FSM -> IDLE. Allocation resumes at T+2.
- Rollback asserted while in RECOVER: repeat the rebuild and stay in RECOVER.
- reset and rollback both high: reset wins.
- free_count is computed from registered free_vec, so it lags grants and frees by one cycle.
- Empty: all gnt = 0.
- Full: every tag is free at most when nothing maps. Not reachable in practice because rrat_table always holds RR_SIZE tags; still no overflow, since the count width covers PRF_SIZE.

Decomposition:
- Shared package (ss_pkg):
  - PRF_TAG_W = $clog2(PRF_SIZE) and typedef prf_tag_t;
  - FSM enum fl_state_t {FL_IDLE, FL_RECOVER}.
- One sub-module: ss_lowest_pick.
  - Input: PRF_SIZE-bit vector.
  - Outputs: found, index of the lowest set bit, and the vector with that bit cleared.
  - Instantiated WIDTH times in a chain, each stage consuming the previous stage's masked vector.

Test Plan:
- Reset released, alloc_req=2'b11 -> gnt=2'b11, tags 32,33. Next cycle free_count=30, next grant gives 34,35.
- Drain to free_count=1 (only tag 63 free), req=2'b11 -> gnt=2'b01, tag 63. Next cycle req=2'b11 -> gnt=2'b00, free_count=0.
- With count=0, free_en=2'b01, free_tag 40, req=2'b01 in the same cycle -> gnt=0. Next cycle req=2'b01 -> gnt=2'b01, tag 40.
- alloc_req=2'b10 with 10 tags free -> gnt=2'b00 (non-prefix request blocked).
- rrat_table identity except arch5->P45, with rollback pulsed one cycle:
  - ready=0 and gnt=0 at T and T+1;
  - at T+2, free_count=32 and req=2'b11 -> tags 5,32;
  - tag 45 is never granted until freed.
- Reset asserted mid-drain (count=7) together with rollback -> next cycle count=32, FSM IDLE, first tags 32,33.
